// File: rtl/dict_hamming_decompressor.sv
// Dictionary/Hamming decompressor: expands a packed word of codebook
// indices into codewords and streams them out serially, MSB first.
module dict_hamming_decompressor #(
    parameter int CHUNK_SIZE    = 4,
    parameter int CODEBOOK_SIZE = 8,
    parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
    parameter int NUM_CHUNKS    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CHUNKS*INDEX_BITS-1:0] compressed_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             data_out,
    output logic                             data_valid,
    input  logic                             out_ready,
    output logic                             decompression_done,
    output logic                             busy
);

    localparam int BW = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int WW = NUM_CHUNKS * INDEX_BITS;
    localparam logic [BW-1:0] BIT_LAST   = BW'(CHUNK_SIZE - 1);
    localparam logic [CW-1:0] CHUNK_LAST = CW'(NUM_CHUNKS - 1);

    // The codebook below is hard-wired for 4-bit codewords and 8 entries.
    generate
        if (CHUNK_SIZE != 4 || CODEBOOK_SIZE != 8) begin : g_param_check
            $error("dict_hamming_decompressor: only CHUNK_SIZE=4, CODEBOOK_SIZE=8");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  state;
    logic [WW-1:0]           word_reg;
    logic [CHUNK_SIZE-1:0]   shift_reg;
    logic [BW-1:0]           bit_cnt;
    logic [CW-1:0]           chunk_cnt;
    logic [CW-1:0]           chunk_nxt;
    logic [INDEX_BITS-1:0]   idx [NUM_CHUNKS];

    function automatic logic [CHUNK_SIZE-1:0] codeword(
        input logic [INDEX_BITS-1:0] i
    );
        logic [CHUNK_SIZE-1:0] cw;
        case (i)
            3'd0:    cw = 4'b0000;
            3'd1:    cw = 4'b0001;
            3'd2:    cw = 4'b1000;
            3'd3:    cw = 4'b0011;
            3'd4:    cw = 4'b1100;
            3'd5:    cw = 4'b0111;
            3'd6:    cw = 4'b1110;
            default: cw = 4'b1111;
        endcase
        return cw;
    endfunction

    assign chunk_nxt = chunk_cnt + 1'b1;
    assign data_out  = shift_reg[CHUNK_SIZE-1];

    // Split the held word into its per-chunk indices.
    always_comb begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            idx[i] = word_reg[i*INDEX_BITS +: INDEX_BITS];
        end
    end

    // Load/send FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            word_reg           <= '0;
            shift_reg          <= '0;
            bit_cnt            <= '0;
            chunk_cnt          <= '0;
            data_valid         <= 1'b0;
            busy               <= 1'b0;
            in_ready           <= 1'b1;
            decompression_done <= 1'b0;
        end else begin
            decompression_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_reg   <= compressed_in;
                        chunk_cnt  <= '0;
                        bit_cnt    <= '0;
                        shift_reg  <= codeword(compressed_in[INDEX_BITS-1:0]);
                        state      <= SEND;
                        data_valid <= 1'b1;
                        busy       <= 1'b1;
                        in_ready   <= 1'b0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (bit_cnt != BIT_LAST) begin
                            shift_reg <= {shift_reg[CHUNK_SIZE-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end else if (chunk_cnt != CHUNK_LAST) begin
                            chunk_cnt <= chunk_nxt;
                            bit_cnt   <= '0;
                            shift_reg <= codeword(idx[chunk_nxt]);
                        end else begin
                            state              <= IDLE;
                            shift_reg          <= '0;
                            bit_cnt            <= '0;
                            chunk_cnt          <= '0;
                            data_valid         <= 1'b0;
                            busy               <= 1'b0;
                            in_ready           <= 1'b1;
                            decompression_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dict_hamming_decompressor.sv
// Self-checking bench for dict_hamming_decompressor: random words and
// backpressure against a codebook-table reference model.
module tb_dict_hamming_decompressor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] compressed_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        data_out;
    logic        data_valid;
    logic        out_ready = 1'b0;
    logic        decompression_done;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [3:0] cb [8] = '{4'h0, 4'h1, 4'h8, 4'h3, 4'hC, 4'h7, 4'hE, 4'hF};
    bit         exp_q [$];
    logic [15:0] rx;

    dict_hamming_decompressor dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .compressed_in      (compressed_in),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .data_out           (data_out),
        .data_valid         (data_valid),
        .out_ready          (out_ready),
        .decompression_done (decompression_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic make_expected(input logic [11:0] w);
        logic [2:0] ix;
        logic [3:0] cw;
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            ix = w[c*3 +: 3];
            cw = cb[ix];
            for (int b = 3; b >= 0; b--) exp_q.push_back(cw[b]);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: valid=%b busy=%b in_ready=%b, want 0 0 1",
                     tag, data_valid, busy, in_ready);
        end
    endtask

    // Called at a negedge with the DUT expected in SEND; returns at the
    // negedge where done should be high. mode 0: ready=1, 1: 1,0,0 pattern,
    // 2: random. If hold, in_valid stays high with compressed_in=alt.
    task automatic stream(input int mode, input bit hold, input logic [11:0] alt);
        int pos = 0;
        int cyc = 0;
        rx = '0;
        while (pos < 16 && cyc < 200) begin
            if (hold) begin
                in_valid = 1'b1;
                compressed_in = alt;
            end
            checks++;
            if (data_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0
                || decompression_done !== 1'b0) begin
                failures++;
                $display("FAIL stream_status bit%0d: valid=%b busy=%b rdy=%b done=%b, want 1 1 0 0",
                         pos, data_valid, busy, in_ready, decompression_done);
            end
            checks++;
            if (data_out !== exp_q[pos]) begin
                failures++;
                $display("FAIL stream_bit%0d: data_out=%b, want %b", pos, data_out, exp_q[pos]);
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) begin
                rx[15-pos] = data_out;
                pos++;
            end
            cyc++;
            @(negedge clk);
        end
        if (pos < 16) begin
            failures++;
            $display("FAIL stream_timeout: sent=%0d, want 16", pos);
        end
        out_ready = 1'b0;
        checks++;
        if (decompression_done !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse: done=%b, want 1", decompression_done);
        end
        check_idle("done_cycle_idle");
    endtask

    task automatic load(input logic [11:0] w);
        compressed_in = w;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready: in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        make_expected(w);
    endtask

    task automatic done_drops;
        @(negedge clk);
        checks++;
        if (decompression_done !== 1'b0) begin
            failures++;
            $display("FAIL done_once: done=%b, want 0", decompression_done);
        end
        check_idle("after_done_idle");
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset_idle");
        checks++;
        if (decompression_done !== 1'b0 || data_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: done=%b data_out=%b, want 0 0",
                     decompression_done, data_out);
        end
    endtask

    task automatic test_basic;
        load(12'hE88);
        stream(0, 1'b0, '0);
        checks++;
        if (rx !== 16'b0000_0001_1000_1111) begin
            failures++;
            $display("FAIL basic_seq: got %b, want 0000000110001111", rx);
        end
        done_drops();
    endtask

    task automatic test_stall;
        load(12'hE88);
        stream(1, 1'b0, '0);
        checks++;
        if (rx !== 16'b0000_0001_1000_1111) begin
            failures++;
            $display("FAIL stall_seq: got %b, want 0000000110001111", rx);
        end
        done_drops();
    endtask

    task automatic test_round_trip;
        load({3'd3, 3'd4, 3'd6, 3'd5});
        stream(2, 1'b0, '0);
        checks++;
        if (rx !== 16'b0111_1110_1100_0011) begin
            failures++;
            $display("FAIL round_trip: got %b, want 0111111011000011", rx);
        end
        done_drops();
    endtask

    task automatic test_back_to_back;
        logic [11:0] w2 = {3'd6, 3'd2, 3'd7, 3'd4};
        load(12'hE88);
        stream(0, 1'b1, w2);
        @(negedge clk);
        in_valid = 1'b0;
        make_expected(w2);
        stream(2, 1'b0, '0);
        done_drops();
    endtask

    task automatic test_reset_mid;
        logic [11:0] w;
        load(12'hE88);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data_out !== exp_q[i]) begin
                failures++;
                $display("FAIL pre_reset_bit%0d: valid=%b out=%b, want 1 %b",
                         i, data_valid, data_out, exp_q[i]);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset_abort_idle");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (decompression_done !== 1'b0 || data_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_abort_quiet: done=%b valid=%b, want 0 0",
                         decompression_done, data_valid);
            end
        end
        out_ready = 1'b0;
        w = 12'($urandom);
        load(w);
        stream(2, 1'b0, '0);
        done_drops();
    endtask

    task automatic test_random;
        logic [11:0] w;
        for (int n = 0; n < 12; n++) begin
            w = 12'($urandom);
            load(w);
            stream(int'($urandom_range(0, 2)), 1'b0, '0);
            if ($urandom_range(0, 1) == 1) done_drops();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_round_trip();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
